// File: rtl/dino_pkg.sv
// Shared constants and FSM state type for the score display blocks.
package dino_pkg;
  localparam int GLYPH_W     = 5;
  localparam int GLYPH_H     = 7;
  localparam int DIGIT_PITCH = 6;
  localparam int NUM_DIGITS  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } state_t;
endpackage

// File: rtl/digit_font.sv
// Combinational 5x7 glyph ROM for decimal digits; row 0 is the top row, col 0 the left column.
module digit_font
  import dino_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [2:0] row,
  input  logic [2:0] col,
  output logic       lit
);

  logic [34:0] glyph;
  logic [5:0]  idx;
  logic        valid;

  always_comb begin
    glyph = '0;
    case (digit)
      4'd0: glyph = {5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110};
      4'd1: glyph = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
      4'd2: glyph = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
      4'd3: glyph = {5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110};
      4'd4: glyph = {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010};
      4'd5: glyph = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110};
      4'd6: glyph = {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110};
      4'd7: glyph = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000};
      4'd8: glyph = {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110};
      4'd9: glyph = {5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100};
      default: glyph = '0;
    endcase
  end

  // Row r occupies bits [34-5r -: 5], left column in the MSB of each row.
  always_comb begin
    valid = (digit <= 4'd9) && (row <= 3'(GLYPH_H - 1)) && (col <= 3'(GLYPH_W - 1));
    idx   = 6'd34 - (6'(row) * 6'd5) - 6'(col);
    lit   = 1'b0;
    if (valid) lit = glyph[idx];
  end

endmodule

// File: rtl/score_render.sv
// Frame-synchronous BCD score renderer: per-frame snapshot, milestone flash FSM and a
// two-stage pixel pipeline from beam position to a registered glyph-on bit.
module score_render
  import dino_pkg::*;
#(
  parameter logic [9:0] X0           = 10'd560,
  parameter logic [9:0] Y0           = 10'd16,
  parameter int         SCALE_SH     = 1,
  parameter bit         LZ_BLANK     = 1'b1,
  parameter int         FLASH_FRAMES = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_tick,
  input  logic [15:0] score,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  output logic        pixel_on,
  output logic        flashing
);

  localparam int         CW    = $clog2(FLASH_FRAMES + 1);
  localparam logic [9:0] BOX_W = 10'((NUM_DIGITS * DIGIT_PITCH) << SCALE_SH);
  localparam logic [9:0] BOX_H = 10'(GLYPH_H << SCALE_SH);

  state_t        state;
  logic [15:0]   disp_q;
  logic [15:0]   flash_val;
  logic [CW-1:0] frame_cnt;
  logic          milestone;

  assign milestone = (score[7:0] == 8'h00) && (score != 16'h0000) && (score != disp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      disp_q    <= 16'h0000;
      flash_val <= 16'h0000;
      frame_cnt <= '0;
      flashing  <= 1'b0;
    end else if (game_tick) begin
      case (state)
        IDLE: begin
          disp_q <= score;
          if (milestone) begin
            flash_val <= score;
            frame_cnt <= '0;
            state     <= FLASH;
            flashing  <= 1'b1;
          end
        end
        FLASH: begin
          // The counter stops at FLASH_FRAMES because the FSM leaves FLASH on that tick.
          frame_cnt <= frame_cnt + 1'b1;
          if (frame_cnt == CW'(FLASH_FRAMES - 1)) begin
            disp_q   <= score;
            state    <= IDLE;
            flashing <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [9:0]  hx, vy;
  logic        in_box;
  logic [4:0]  cell_c;
  logic [1:0]  dig;
  logic [4:0]  dig_base;
  logic [2:0]  gc, gr;
  logic [15:0] val;
  logic [3:0]  nib;
  logic        lead_zero, visible, blank;

  always_comb begin
    hx     = hpos - X0;
    vy     = vpos - Y0;
    in_box = (hpos >= X0) && (vpos >= Y0) && (hx < BOX_W) && (vy < BOX_H);
    cell_c = 5'(hx >> SCALE_SH);
    gr     = 3'(vy >> SCALE_SH);
    if (cell_c < 5'd6) begin
      dig = 2'd0; dig_base = 5'd0;
    end else if (cell_c < 5'd12) begin
      dig = 2'd1; dig_base = 5'd6;
    end else if (cell_c < 5'd18) begin
      dig = 2'd2; dig_base = 5'd12;
    end else begin
      dig = 2'd3; dig_base = 5'd18;
    end
    gc  = 3'(cell_c - dig_base);
    val = (state == FLASH) ? flash_val : disp_q;
    case (dig)
      2'd0: begin nib = val[15:12]; lead_zero = (val[15:12] == 4'h0); end
      2'd1: begin nib = val[11:8];  lead_zero = (val[15:8]  == 8'h00); end
      2'd2: begin nib = val[7:4];   lead_zero = (val[15:4]  == 12'h000); end
      default: begin nib = val[3:0]; lead_zero = 1'b0; end
    endcase
    visible = (state == IDLE) || !frame_cnt[3];
    blank   = (nib > 4'd9) || (gc == 3'd5) || !visible || (LZ_BLANK && lead_zero);
  end

  // Stage 1: geometry decode and digit selection
  logic       vld_p1;
  logic       blank_p1;
  logic [3:0] nib_p1;
  logic [2:0] gc_p1, gr_p1;

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= in_box;
  end

  always_ff @(posedge clk) begin
    blank_p1 <= blank;
    nib_p1   <= nib;
    gc_p1    <= gc;
    gr_p1    <= gr;
  end

  logic font_lit;

  digit_font u_font (
    .digit (nib_p1),
    .row   (gr_p1),
    .col   (gc_p1),
    .lit   (font_lit)
  );

  // Stage 2: glyph lookup and final pixel register
  always_ff @(posedge clk) begin
    if (rst) pixel_on <= 1'b0;
    else     pixel_on <= vld_p1 & ~blank_p1 & font_lit;
  end

endmodule

// File: tb/tb_score_render.sv
// Randomized self-checking bench for score_render against a frame-level behavioural model.
module tb_score_render;

  localparam int X0 = 560;
  localparam int Y0 = 16;
  localparam int FF = 48;

  localparam logic [4:0] FONT [10][7] = '{
    '{5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110},
    '{5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110},
    '{5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111},
    '{5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110},
    '{5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010},
    '{5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110},
    '{5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110},
    '{5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000},
    '{5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110},
    '{5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100}
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        game_tick;
  logic [15:0] score;
  logic [9:0]  hpos, vpos;
  logic        pixel_on, flashing;
  logic        pixel_on_nlz, flashing_nlz;

  always #5 clk = ~clk;

  score_render dut (
    .clk       (clk),
    .rst       (rst),
    .game_tick (game_tick),
    .score     (score),
    .hpos      (hpos),
    .vpos      (vpos),
    .pixel_on  (pixel_on),
    .flashing  (flashing)
  );

  score_render #(.LZ_BLANK(1'b0)) dut_nlz (
    .clk       (clk),
    .rst       (rst),
    .game_tick (game_tick),
    .score     (score),
    .hpos      (hpos),
    .vpos      (vpos),
    .pixel_on  (pixel_on_nlz),
    .flashing  (flashing_nlz)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame-level model: displayed value, flash value, flash active, frames spent flashing.
  logic [15:0] m_disp, m_fv;
  bit          m_fl;
  int          m_cnt;

  task automatic model_reset();
    m_disp = 16'h0000; m_fv = 16'h0000; m_fl = 0; m_cnt = 0;
  endtask

  task automatic model_tick(input logic [15:0] s);
    if (!m_fl) begin
      if (s[7:0] == 8'h00 && s != 16'h0000 && s != m_disp) begin
        m_fv = s; m_fl = 1; m_cnt = 0;
      end
      m_disp = s;
    end else begin
      if (m_cnt == FF - 1) begin
        m_disp = s; m_fl = 0;
      end
      m_cnt++;
    end
  endtask

  function automatic bit ref_pix(input int h, input int v, input bit lz);
    int c, r, d, gc, nib;
    logic [15:0] val;
    logic [4:0]  rb;
    bit vis;
    if (h < X0 || v < Y0) return 0;
    c = (h - X0) / 2;
    r = (v - Y0) / 2;
    if (c >= 24 || r >= 7) return 0;
    d   = c / 6;
    gc  = c % 6;
    val = m_fl ? m_fv : m_disp;
    vis = !m_fl || ((m_cnt / 8) % 2 == 0);
    nib = int'((val >> (4 * (3 - d))) & 16'hF);
    if (!vis || gc == 5 || nib > 9) return 0;
    if (lz && d < 3 && (val >> (12 - 4 * d)) == 16'h0) return 0;
    rb = FONT[nib][r];
    return rb[4 - gc];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [15:0] s);
    score     = s;
    game_tick = 1'b1;
    model_tick(s);
    step();
    game_tick = 1'b0;
    chk("flashing", flashing, m_fl);
    chk("disp_q", dut.disp_q, m_disp);
  endtask

  // Drives one beam position per clock; each output is checked against the position two clocks back.
  task automatic scan(input int n, input bit rnd);
    bit ea[$];
    bit eb[$];
    int h, v;
    h = int'(hpos); v = int'(vpos);
    for (int i = 0; i < n + 2; i++) begin
      if (i >= 2) begin
        chk("pix_lz", pixel_on, ea[i-2]);
        chk("pix_nlz", pixel_on_nlz, eb[i-2]);
      end
      if (i < n) begin
        if (rnd) begin
          h = X0 - 6 + int'($urandom_range(0, 60));
          v = Y0 - 3 + int'($urandom_range(0, 20));
        end else begin
          h = X0 - 2 + (i % 52);
          v = Y0 - 1 + (i / 52);
        end
      end
      hpos = 10'(h);
      vpos = 10'(v);
      ea.push_back(ref_pix(h, v, 1'b1));
      eb.push_back(ref_pix(h, v, 1'b0));
      step();
    end
  endtask

  task automatic hold_chk(input string tag, input int h, input int v);
    hpos = 10'(h);
    vpos = 10'(v);
    step();
    step();
    chk(tag, pixel_on, ref_pix(h, v, 1'b1));
    chk(tag, pixel_on_nlz, ref_pix(h, v, 1'b0));
  endtask

  function automatic logic [15:0] rnd_score();
    logic [15:0] s;
    s = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
         4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    case ($urandom_range(0, 3))
      0: s[7:0] = 8'h00;
      1: s[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      2: s[15:8] = 8'h00;
      default: ;
    endcase
    return s;
  endfunction

  initial begin
    rst = 1'b1; game_tick = 1'b0; score = 16'h0000; hpos = 10'd0; vpos = 10'd0;
    model_reset();
    repeat (3) step();
    chk("rst_pixel_on", pixel_on, 0);
    chk("rst_flashing", flashing, 0);
    chk("rst_disp_q", dut.disp_q, 16'h0000);
    chk("rst_flash_val", dut.flash_val, 16'h0000);
    rst = 1'b0;
    step();

    // Small value with leading zeros
    tick(16'h0042);
    chk("disp_0042", dut.disp_q, 16'h0042);
    scan(52 * 16, 1'b0);
    hold_chk("d2_gc0_gr0", X0 + 12 * 2, Y0);
    hold_chk("d2_lit", X0 + 15 * 2, Y0);

    // All-zero score: one digit with blanking, four without
    tick(16'h0000);
    scan(52 * 16, 1'b0);

    // Milestone flash, with a second milestone ignored while flashing
    tick(16'h0099);
    chk("no_flash_0099", flashing, 0);
    tick(16'h0100);
    chk("flash_0100", flashing, 1);
    for (int k = 1; k <= FF; k++) begin
      tick(k >= 10 ? 16'h0200 : 16'h0100);
      chk("flash_val_hold", dut.flash_val, 16'h0100);
      if (k == 3 || k == 9 || k == 16) scan(52 * 16, 1'b0);
      else scan(20, 1'b1);
    end
    chk("flash_exit", flashing, 0);
    chk("exit_disp", dut.disp_q, 16'h0200);
    tick(16'h0200);
    chk("no_reflash", flashing, 0);

    // Reset during a flash
    tick(16'h0300);
    chk("flash_0300", flashing, 1);
    repeat (20) tick(16'h0300);
    hpos = 10'(X0 + 2 * 13);
    vpos = 10'(Y0);
    step();
    rst = 1'b1;
    step();
    model_reset();
    chk("rst_mid_flashing", flashing, 0);
    chk("rst_mid_pixel", pixel_on, 0);
    chk("rst_mid_disp", dut.disp_q, 16'h0000);
    rst = 1'b0;

    // Box edges and an invalid nibble
    tick(16'h1A58);
    hold_chk("left_edge", X0 - 1, Y0 + 2);
    hold_chk("right_edge", X0 + 48, Y0 + 2);
    hold_chk("bad_nibble", X0 + 6 * 2 + 2, Y0 + 4);
    scan(52 * 16, 1'b0);

    // Randomized scores and beam positions
    for (int n = 0; n < 80; n++) begin
      tick(rnd_score());
      scan(30, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_render.md
Name: score_render

Overview:
- Display-side consumer of the 16-bit packed-BCD score produced by the score counter. Four digit values, most significant nibble first.
- Snapshots the score once per frame on game_tick, so digits never tear mid-frame.
- Blinks the value for a fixed number of frames each time the score reaches a multiple of 100.
- Outputs a registered per-pixel "on" bit for the VGA compositor, driven by the beam position.

Parameters:
- X0, 10'd560, left pixel column of the score box.
- Y0, 10'd16, top pixel row of the score box.
- SCALE_SH, 1, log2 of pixels per glyph cell. Cell size is 2^SCALE_SH pixels square.
- LZ_BLANK, 1, leading-zero blanking enable. 1 = blank leading zeros, 0 = always show four digits.
- FLASH_FRAMES, 48, number of game_tick frames a milestone flash lasts.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- game_tick  in  1  end-of-frame pulse, one clk wide, 60 Hz.
- score  in  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- hpos  in  10  current beam column.
- vpos  in  10  current beam row.
- pixel_on  out  1  registered; 1 = score glyph pixel lit at the (hpos,vpos) sampled 2 cycles earlier.
- flashing  out  1  registered; 1 while the FSM is in FLASH.

Behaviour:
- Reset (rst=1 at a clk edge): pixel_on=0, flashing=0, state=IDLE, disp_q=16'h0000, flash_val=0, frame_cnt=0.
  - Reset applied mid-flash takes effect on that same edge; state returns to IDLE.
- Display register disp_q is updated only on game_tick edges.
- FSM, 2 states.
  - IDLE, on game_tick:
    - Milestone condition: score[7:0]==8'h00 AND score!=16'h0000 AND score!=disp_q.
    - If milestone: flash_val<=score, disp_q<=score, frame_cnt<=0, state<=FLASH.
    - Otherwise: disp_q<=score.
  - FLASH, on game_tick:
    - frame_cnt<=frame_cnt+1. Counter width is clog2(FLASH_FRAMES+1); it never wraps.
    - When frame_cnt==FLASH_FRAMES-1: disp_q<=score, state<=IDLE.
    - New milestones arriving during FLASH are ignored; flash_val is held and disp_q is not updated from score.
  - flashing = (state==FLASH).
- Visibility:
  - IDLE: always visible.
  - FLASH: visible when frame_cnt[3]==0, giving 8 frames on, 8 frames off. Rendered value is flash_val.
- Geometry:
  - Glyph is 5 cols x 7 rows of cells. Digit pitch is 6 cells; cell col 5 of each digit is a blank gap.
  - Box spans hpos in [X0, X0+24*2^SCALE_SH) and vpos in [Y0, Y0+7*2^SCALE_SH). Everything outside the box is off.
- Pixel pipeline, latency exactly 2 clk from hpos/vpos to pixel_on.
  - Stage 1 (registered):
    - in_box flag.
    - Cell column c=(hpos-X0)>>SCALE_SH, range 0..23.
    - Digit index d=c/6 via a comparison chain (no divider); d=0 is leftmost (thousands).
    - Glyph column gc=c-6d.
    - Glyph row gr=(vpos-Y0)>>SCALE_SH.
    - Selected nibble from disp_q or flash_val.
    - Blank flag. A digit is blanked when any of these hold:
      - nibble>4'd9;
      - gc==5;
      - not visible;
      - LZ_BLANK=1 and d<3 and every nibble at index <=d is zero.
    - The ones digit (d=3) is never blanked by leading-zero logic.
  - Stage 2 (registered): pixel_on <= in_box & ~blank & font(nibble,gr,gc).
- Arithmetic:
  - Subtractions use 10-bit unsigned values.
  - When hpos<X0 or vpos<Y0, in_box is forced to 0 before c or gr is used.
- Score wrap 9999->0000 needs no special handling: 0 is never a milestone.

Decomposition:
- Shared package (dino_pkg):
  - GLYPH_W=5, GLYPH_H=7, DIGIT_PITCH=6, NUM_DIGITS=4 constants.
  - FSM state typedef {IDLE, FLASH}.
- Sub-module digit_font: combinational 5x7 ROM.
  - Inputs: digit[3:0], row[2:0], col[2:0]. Output: bit.
  - Returns 0 for digit>9, row>6 or col>4.

Test Plan:
1. rst for 3 clk, score=16'h0042, one game_tick -> disp_q=16'h0042. Scan the box: digits 0 and 1 are fully dark; pixel at gc=0,gr=0 of d=2 matches font('4'); pixel_on lags hpos by exactly 2 clk.
2. LZ_BLANK=1, score=16'h0000, tick -> only d=3 shows '0'. With LZ_BLANK=0 -> all four digits show '0'.
3. score 16'h0099 then 16'h0100 on successive ticks -> flashing=1 after the second tick.
   - Digits visible for ticks 0-7, dark for ticks 8-15, visible again from tick 16.
   - flashing=0 after 48 ticks, and disp_q = score at that tick.
4. During FLASH, score=16'h0200 on a tick -> flash_val stays 16'h0100 and flashing stays 1. After exit, 0200 is not re-flashed, because score==disp_q.
5. rst asserted at frame_cnt=20 of a flash -> next clk: flashing=0, pixel_on=0, disp_q=0.
6. hpos=X0-1 and hpos=X0+48 with SCALE_SH=1, plus an invalid nibble 4'hA -> pixel_on=0 in all cases.
